// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher. The caller supplies the ciphertext. The
// round keys come from the key SRAM (registered read) and are fetched in the
// order 10 down to 0. One round runs per clock, so the result is ready 12
// cycles after the start pulse.
module inv_cipher #(
  parameter int BLK_S = 128,
  parameter int KEY_S = 128,
  parameter int NR    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:BLK_S-1] ciphertext,
  input  logic [0:KEY_S-1] key,
  output logic [0:3]       round_no,
  output logic             r_e,
  output logic [0:BLK_S-1] plaintext,
  output logic             en_o
);

  typedef enum logic [1:0] {IDLE, FETCH, ROUND} state_t;

  // Inverse S-box, entry b at bits [8*b +: 8].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state is row i%4, column i/4 (column-major).
  function automatic logic [0:BLK_S-1] inv_shift_rows(input logic [0:BLK_S-1] s);
    logic [0:BLK_S-1] o;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:BLK_S-1] inv_sub_bytes(input logic [0:BLK_S-1] s);
    logic [0:BLK_S-1] o;
    logic [7:0]       b;
    o = s;
    for (int i = 0; i < 16; i++) begin
      b = s[8*i +: 8];
      o[8*i +: 8] = INV_SBOX[8*int'(b) +: 8];
    end
    return o;
  endfunction

  // Multiplies by 0e/0b/0d/09 are built from the x2/x4/x8 xtime chain.
  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [0:31] o;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    o[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    o[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    o[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    o[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return o;
  endfunction

  function automatic logic [0:BLK_S-1] inv_mix_columns(input logic [0:BLK_S-1] s);
    logic [0:BLK_S-1] o;
    o = s;
    for (int c = 0; c < 4; c++) begin
      o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    end
    return o;
  endfunction

  state_t           state_q, state_d;
  logic [0:BLK_S-1] blk_q, blk_d;
  logic [3:0]       kidx_q, kidx_d;
  logic [0:3]       round_no_q, round_no_d;
  logic             r_e_q, r_e_d;
  logic [0:BLK_S-1] plaintext_q, plaintext_d;
  logic             en_o_q, en_o_d;

  logic [0:BLK_S-1] ark;
  logic [0:BLK_S-1] rnd_full;

  // Round datapath: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
  always_comb begin
    ark      = inv_sub_bytes(inv_shift_rows(blk_q)) ^ key;
    rnd_full = inv_mix_columns(ark);
  end

  // Next-state logic. kidx_q is the index of the round key currently on 'key'.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    kidx_d      = kidx_q;
    round_no_d  = round_no_q;
    r_e_d       = r_e_q;
    plaintext_d = plaintext_q;
    en_o_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          blk_d      = ciphertext;
          round_no_d = 4'(NR);
          r_e_d      = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        round_no_d = 4'(NR - 1);
        kidx_d     = 4'(NR);
        state_d    = ROUND;
      end
      ROUND: begin
        if (kidx_q == 4'(NR)) begin
          blk_d = blk_q ^ key;
        end else if (kidx_q != 4'd0) begin
          blk_d = rnd_full;
        end else begin
          plaintext_d = ark;
          en_o_d      = 1'b1;
          state_d     = IDLE;
        end
        if (kidx_q != 4'd0) kidx_d = kidx_q - 4'd1;
        // Address 0 was issued on the previous edge; the read bus goes quiet
        // while key1 is consumed.
        if (kidx_q == 4'd1) begin
          r_e_d      = 1'b0;
          round_no_d = 4'd0;
        end else if (round_no_q != 4'd0) begin
          round_no_d = round_no_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and all registered outputs; reset clears everything including data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      kidx_q      <= '0;
      round_no_q  <= '0;
      r_e_q       <= 1'b0;
      plaintext_q <= '0;
      en_o_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      kidx_q      <= kidx_d;
      round_no_q  <= round_no_d;
      r_e_q       <= r_e_d;
      plaintext_q <= plaintext_d;
      en_o_q      <= en_o_d;
    end
  end

  assign round_no  = round_no_q;
  assign r_e       = r_e_q;
  assign plaintext = plaintext_q;
  assign en_o      = en_o_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: key SRAM model with registered read, FIPS-197 known
// answers, address sequence, busy/back-to-back, mid-op reset and random
// blocks encrypted by a reference model.
module tb_inv_cipher;

  logic         clk;
  logic         reset;
  logic         en;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [3:0]   round_no;
  logic         r_e;
  logic [127:0] plaintext;
  logic         en_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] rk_tab [0:1][0:10];
  int           key_sel;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  inv_cipher #(.BLK_S(128), .KEY_S(128), .NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ciphertext (ciphertext),
    .key        (key),
    .round_no   (round_no),
    .r_e        (r_e),
    .plaintext  (plaintext),
    .en_o       (en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key SRAM: registered read, one cycle latency.
  always @(posedge clk) begin
    if (r_e && round_no <= 4'd10) key <= rk_tab[key_sel][round_no];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from its definition: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input int sel, input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference AES-128 encryption used to build random decryption vectors.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int sel);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[sel][0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tab[sel][r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one decryption at the current negedge and follow it to en_o.
  // Optionally checks the SRAM address sequence and pokes en while busy.
  task automatic run_op(input logic [127:0] ct, input logic [127:0] exp_pt,
                        input logic [127:0] hold, input bit chk_addr,
                        input bit inject, input string tag);
    en = 1'b1;
    ciphertext = ct;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("%s_en_o_k%0d", tag, k), 128'(en_o), 128'(k == 12));
      if (k < 12) check($sformatf("%s_hold_k%0d", tag, k), plaintext, hold);
      else        check($sformatf("%s_plaintext", tag), plaintext, exp_pt);
      if (chk_addr) begin
        check($sformatf("%s_r_e_k%0d", tag, k), 128'(r_e), 128'(k <= 10));
        check($sformatf("%s_round_no_k%0d", tag, k), 128'(round_no),
              (k <= 10) ? 128'(10 - k) : 128'd0);
      end
      ciphertext = ~ct;
      en = (inject && (k == 2 || k == 6)) ? 1'b1 : 1'b0;
    end
  endtask

  logic [127:0] prev, rpt, rct;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    ciphertext = '0;
    key_sel = 0;
    build_sbox();
    expand_key(0, C1_KEY);
    expand_key(1, B_KEY);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_round_no", 128'(round_no), 128'd0);
    check("rst_r_e", 128'(r_e), 128'd0);
    check("rst_plaintext", plaintext, 128'd0);
    check("rst_en_o", 128'(en_o), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with full address sequence
    run_op(C1_CT, C1_PT, 128'd0, 1'b1, 1'b0, "c1");
    @(negedge clk);
    check("c1_en_o_width", 128'(en_o), 128'd0);
    check("c1_idle_r_e", 128'(r_e), 128'd0);
    check("c1_idle_round_no", 128'(round_no), 128'd0);
    check("c1_pt_held", plaintext, C1_PT);

    // FIPS-197 Appendix B
    key_sel = 1;
    run_op(B_CT, B_PT, C1_PT, 1'b1, 1'b0, "fipsb");

    // Busy pulses ignored, issued back-to-back after the previous result
    key_sel = 0;
    run_op(C1_CT, C1_PT, B_PT, 1'b0, 1'b1, "busy");
    key_sel = 1;
    run_op(B_CT, B_PT, C1_PT, 1'b0, 1'b0, "b2b");
    @(negedge clk);
    check("b2b_en_o_width", 128'(en_o), 128'd0);

    // Reset mid-operation, with en asserted on the reset edge
    key_sel = 0;
    en = 1'b1;
    ciphertext = C1_CT;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      en = 1'b0;
    end
    reset = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("midrst_en_o", 128'(en_o), 128'd0);
    check("midrst_plaintext", plaintext, 128'd0);
    check("midrst_r_e", 128'(r_e), 128'd0);
    check("midrst_round_no", 128'(round_no), 128'd0);
    reset = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("postrst_r_e", 128'(r_e), 128'd0);
    check("postrst_round_no", 128'(round_no), 128'd0);
    run_op(C1_CT, C1_PT, 128'd0, 1'b1, 1'b0, "c1_after_rst");

    // Random blocks under the C.1 key, back-to-back
    prev = C1_PT;
    for (int n = 0; n < 12; n++) begin
      rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
      rct = aes_enc(rpt, 0);
      run_op(rct, rpt, prev, 1'b0, 1'b0, $sformatf("rand%0d", n));
      prev = rpt;
    end
    @(negedge clk);
    check("final_en_o", 128'(en_o), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
